ballot_session_ctrl: RTL and testbench

- Sequences a single voter ballot from officer enable through candidate button qualification to one committed vote, then enforces a lockout before the next ballot can open.
- Sits between the debounced candidate button levels and the per-candidate 8-bit vote counters.
- Drives one-cycle increment strobes to those counters and the valid_vote_casted pulse consumed by the LED flash logic.
- Active only in voting mode (mode==0); result mode (mode==1) closes any open ballot.

---
 rtl/ballot_session_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_ballot_session_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_session_ctrl.sv
// Purpose : sequences one voter ballot (open -> qualify one button -> commit one vote -> lockout).
// Latency : armed rises 1 cycle after ballot_enable; cand_inc fires the cycle after the
//           STABLE_CYCLES-th consecutive one-hot sample of the same button.
// Backpressure: none; inputs are levels, outputs are fire-and-forget single-cycle strobes.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   mode                0 = voting, 1 = result display (closes any open ballot)
//   ballot_enable       officer request to open a ballot, honoured only while idle
//   button_level[3:0]   debounced candidate buttons, bit i = candidate i+1
//   cand_inc[3:0]       one-hot increment strobe to candidate counter i
//   valid_vote_casted   pulse coincident with cand_inc
//   multi_press         pulse when a multi-button press is rejected
//   ballot_timeout      pulse when an open ballot expires without activity
//   armed               ballot open and waiting for / qualifying a press
//   busy                any state other than idle
//   votes_total[15:0]   saturating count of committed votes

module ballot_session_ctrl #(
  parameter int ARM_TIMEOUT    = 1000,
  parameter int STABLE_CYCLES  = 4,
  parameter int LOCKOUT_CYCLES = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode,
  input  logic        ballot_enable,
  input  logic [3:0]  button_level,
  output logic [3:0]  cand_inc,
  output logic        valid_vote_casted,
  output logic        multi_press,
  output logic        ballot_timeout,
  output logic        armed,
  output logic        busy,
  output logic [15:0] votes_total
);

  // Counter widths sized to hold their load values.
  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [TW-1:0] ARM_LOAD    = TW'(ARM_TIMEOUT);
  localparam logic [SW-1:0] STABLE_LOAD = SW'(STABLE_CYCLES);
  localparam logic [LW-1:0] LOCK_LOAD   = LW'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARMED        = 3'd1,
    S_QUALIFY      = 3'd2,
    S_COMMIT       = 3'd3,
    S_WAIT_RELEASE = 3'd4,
    S_LOCKOUT      = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cand_sel_q, cand_sel_d;
  logic [SW-1:0]  stable_q, stable_d;
  logic [SW-1:0]  stable_inc;
  logic [TW-1:0]  arm_cnt_q, arm_cnt_d;
  logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
  logic           done_q, done_d;
  logic           multi_q, multi_d;
  logic           timeout_q, timeout_d;
  logic [15:0]    votes_q, votes_d;

  // Button classification. Clearing the lowest set bit leaves a non-zero
  // value only when two or more buttons are pressed.
  logic btn_any;
  logic btn_multi;
  logic btn_one;

  assign btn_any    = |button_level;
  assign btn_multi  = |(button_level & (button_level - 4'd1));
  assign btn_one    = btn_any & ~btn_multi;
  assign stable_inc = stable_q + SW'(1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cand_sel_q <= 4'd0;
      stable_q   <= '0;
      arm_cnt_q  <= '0;
      lock_cnt_q <= '0;
      done_q     <= 1'b0;
      multi_q    <= 1'b0;
      timeout_q  <= 1'b0;
      votes_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      cand_sel_q <= cand_sel_d;
      stable_q   <= stable_d;
      arm_cnt_q  <= arm_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      done_q     <= done_d;
      multi_q    <= multi_d;
      timeout_q  <= timeout_d;
      votes_q    <= votes_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cand_sel_d = cand_sel_q;
    stable_d   = stable_q;
    arm_cnt_d  = arm_cnt_q;
    lock_cnt_d = lock_cnt_q;
    done_d     = done_q;
    multi_d    = 1'b0;
    timeout_d  = 1'b0;
    votes_d    = votes_q;

    case (state_q)
      S_IDLE: begin
        if (ballot_enable && !mode) begin
          state_d   = S_ARMED;
          arm_cnt_d = ARM_LOAD;
          done_d    = 1'b0;
        end
      end

      S_ARMED: begin
        if (mode) begin
          state_d = S_IDLE;
        end else if (btn_multi) begin
          multi_d = 1'b1;
          done_d  = 1'b0;
          state_d = S_WAIT_RELEASE;
        end else if (btn_one) begin
          cand_sel_d = button_level;
          stable_d   = SW'(1);
          // A single sample is already enough when STABLE_CYCLES is 1.
          state_d    = (STABLE_CYCLES <= 1) ? S_COMMIT : S_QUALIFY;
        end else if (arm_cnt_q <= TW'(1)) begin
          // Last idle cycle of the window: expire the ballot.
          arm_cnt_d = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q - TW'(1);
        end
      end

      S_QUALIFY: begin
        if (mode) begin
          state_d = S_IDLE;
        end else if (button_level == cand_sel_q) begin
          stable_d = stable_inc;
          if (stable_inc >= STABLE_LOAD) begin
            state_d = S_COMMIT;
          end
        end else begin
          // Glitch or change of mind: re-arm silently, the idle window
          // keeps whatever it had left.
          state_d = S_ARMED;
        end
      end

      S_COMMIT: begin
        // Single atomic cycle; mode and buttons are deliberately not looked at.
        done_d  = 1'b1;
        state_d = S_WAIT_RELEASE;
        if (votes_q != 16'hFFFF) begin
          votes_d = votes_q + 16'd1;
        end
      end

      S_WAIT_RELEASE: begin
        if (mode && !done_q) begin
          state_d = S_IDLE;
        end else if (!btn_any) begin
          if (done_q) begin
            state_d    = S_LOCKOUT;
            lock_cnt_d = LOCK_LOAD;
          end else begin
            state_d = S_ARMED;
          end
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt_q <= LW'(1)) begin
          lock_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - LW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    cand_inc          = 4'd0;
    valid_vote_casted = 1'b0;
    if (state_q == S_COMMIT) begin
      cand_inc          = cand_sel_q;
      valid_vote_casted = 1'b1;
    end
    multi_press    = multi_q;
    ballot_timeout = timeout_q;
    armed          = (state_q == S_ARMED) || (state_q == S_QUALIFY);
    busy           = (state_q != S_IDLE);
    votes_total    = votes_q;
  end

  // ---------------------------------------------------------------------------
  // Structural guarantees of the strobe outputs
  // ---------------------------------------------------------------------------
  a_cand_onehot : assert property (@(posedge clock) disable iff (reset)
    $onehot0(cand_inc));

  a_pulse_excl : assert property (@(posedge clock) disable iff (reset)
    $onehot0({multi_press, ballot_timeout, valid_vote_casted}));

  a_vote_pair : assert property (@(posedge clock) disable iff (reset)
    valid_vote_casted == (cand_inc != 4'd0));

endmodule

// File: tb/tb_ballot_session_ctrl.sv
module tb_ballot_session_ctrl;

  localparam int ARM_T = 10;
  localparam int STAB  = 4;
  localparam int LOCK  = 50;

  logic        clock = 1'b0;
  logic        reset;
  logic        mode;
  logic        ballot_enable;
  logic [3:0]  button_level;
  logic [3:0]  cand_inc;
  logic        valid_vote_casted;
  logic        multi_press;
  logic        ballot_timeout;
  logic        armed;
  logic        busy;
  logic [15:0] votes_total;

  ballot_session_ctrl #(
    .ARM_TIMEOUT   (ARM_T),
    .STABLE_CYCLES (STAB),
    .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mode             (mode),
    .ballot_enable    (ballot_enable),
    .button_level     (button_level),
    .cand_inc         (cand_inc),
    .valid_vote_casted(valid_vote_casted),
    .multi_press      (multi_press),
    .ballot_timeout   (ballot_timeout),
    .armed            (armed),
    .busy             (busy),
    .votes_total      (votes_total)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: one entry per vote expected, holding the candidate strobe and
  // the cycle on which it must appear.
  typedef struct {
    logic [3:0] cand;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clock) begin
    if (!reset && (cand_inc != 4'd0 || valid_vote_casted)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: cand_inc=%b valid=%b at cycle %0d, none expected",
                 cand_inc, valid_vote_casted, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if (cand_inc !== mon_e.cand)
          $display("FAIL strobe_cand: got %b want %b", cand_inc, mon_e.cand);
        else n_pass++;
        n_checks++;
        if (valid_vote_casted !== 1'b1)
          $display("FAIL strobe_valid: got %b want 1", valid_vote_casted);
        else n_pass++;
        n_checks++;
        if (cyc !== mon_e.at)
          $display("FAIL strobe_cycle: got %0d want %0d", cyc, mon_e.at);
        else n_pass++;
      end
    end
    if (!reset && (multi_press || ballot_timeout || valid_vote_casted)) begin
      n_checks++;
      if (!$onehot0({multi_press, ballot_timeout, valid_vote_casted}))
        $display("FAIL pulse_exclusive: multi=%b timeout=%b valid=%b",
                 multi_press, ballot_timeout, valid_vote_casted);
      else n_pass++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic open_ballot(input string tag);
    ballot_enable = 1'b1;
    @(negedge clock);
    ballot_enable = 1'b0;
    n_checks++;
    if (armed !== 1'b1) $display("FAIL %s_open_armed: got %b want 1", tag, armed);
    else n_pass++;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    button_level = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (busy === 1'b1 && k < bound) begin
      @(negedge clock);
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s_idle_wait: busy=%b after %0d cycles", tag, busy, k);
    else n_pass++;
  endtask

  // Full ballot that is expected to commit for candidate pattern v.
  task automatic cast_vote(input string tag, input logic [3:0] v);
    open_ballot(tag);
    exp_q.push_back('{cand: v, at: cyc + STAB});
    hold(v, STAB);
    button_level = 4'd0;
    wait_idle(tag, 200);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; ballot_enable = 1'b0; button_level = 4'd0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({cand_inc, valid_vote_casted, multi_press, ballot_timeout, armed, busy} !== 9'd0)
      $display("FAIL reset_outputs: got %b want 0",
               {cand_inc, valid_vote_casted, multi_press, ballot_timeout, armed, busy});
    else n_pass++;
    n_checks++;
    if (votes_total !== 16'd0) $display("FAIL reset_votes: got %h want 0000", votes_total);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic_vote();
    int n = 0;
    int k = 0;
    open_ballot("basic");
    exp_q.push_back('{cand: 4'b0010, at: cyc + STAB});
    hold(4'b0010, 6);
    button_level = 4'd0;
    // WAIT_RELEASE sees the release on the next edge, then LOCK cycles of lockout.
    do begin
      @(negedge clock);
      if (busy === 1'b1) n++;
      k++;
    end while (busy === 1'b1 && k < 200);
    n_checks++;
    if (n !== LOCK) $display("FAIL basic_lockout_len: got %0d want %0d", n, LOCK);
    else n_pass++;
    n_checks++;
    if (votes_total !== 16'd1) $display("FAIL basic_total: got %0d want 1", votes_total);
    else n_pass++;
  endtask

  task automatic test_glitch();
    open_ballot("glitch");
    hold(4'b0100, 2);
    button_level = 4'd0;
    @(negedge clock);
    n_checks++;
    if (armed !== 1'b1) $display("FAIL glitch_armed: got %b want 1", armed);
    else n_pass++;
    n_checks++;
    if (votes_total !== 16'd1) $display("FAIL glitch_no_vote: got %0d want 1", votes_total);
    else n_pass++;
    exp_q.push_back('{cand: 4'b0100, at: cyc + STAB});
    hold(4'b0100, STAB);
    button_level = 4'd0;
    wait_idle("glitch", 200);
    n_checks++;
    if (votes_total !== 16'd2) $display("FAIL glitch_total: got %0d want 2", votes_total);
    else n_pass++;
  endtask

  task automatic test_multi();
    open_ballot("multi");
    button_level = 4'b1001;
    @(negedge clock);
    n_checks++;
    if (multi_press !== 1'b1) $display("FAIL multi_pulse: got %b want 1", multi_press);
    else n_pass++;
    n_checks++;
    if (armed !== 1'b0) $display("FAIL multi_wait_armed: got %b want 0", armed);
    else n_pass++;
    button_level = 4'd0;
    @(negedge clock);
    n_checks++;
    if ({multi_press, armed} !== 2'b01)
      $display("FAIL multi_rearm: got multi/armed=%b want 01", {multi_press, armed});
    else n_pass++;
    exp_q.push_back('{cand: 4'b1000, at: cyc + STAB});
    hold(4'b1000, STAB);
    button_level = 4'd0;
    wait_idle("multi", 200);
    n_checks++;
    if (votes_total !== 16'd3) $display("FAIL multi_total: got %0d want 3", votes_total);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int k = 0;
    open_ballot("timeout");
    do begin
      @(negedge clock);
      k++;
    end while (ballot_timeout !== 1'b1 && k < 50);
    n_checks++;
    if (k !== ARM_T) $display("FAIL timeout_cycle: got %0d want %0d", k, ARM_T);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL timeout_idle: busy=%b want 0", busy);
    else n_pass++;
    hold(4'b0001, 6);
    button_level = 4'd0;
    @(negedge clock);
    n_checks++;
    if ({armed, votes_total} !== {1'b0, 16'd3})
      $display("FAIL timeout_late_press: armed=%b total=%0d want 0/3", armed, votes_total);
    else n_pass++;
  endtask

  task automatic test_mode_lockout();
    open_ballot("abort");
    hold(4'b0010, 2);
    mode = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({armed, busy} !== 2'b00) $display("FAIL abort_idle: armed/busy=%b want 00", {armed, busy});
    else n_pass++;
    mode = 1'b0;
    hold(4'b0010, 5);
    button_level = 4'd0;
    @(negedge clock);
    n_checks++;
    if (votes_total !== 16'd3) $display("FAIL abort_total: got %0d want 3", votes_total);
    else n_pass++;

    open_ballot("lockout");
    exp_q.push_back('{cand: 4'b0001, at: cyc + STAB});
    hold(4'b0001, 12);
    button_level = 4'd0;
    @(negedge clock);
    ballot_enable = 1'b1;
    @(negedge clock);
    ballot_enable = 1'b0;
    n_checks++;
    if ({busy, armed} !== 2'b10) $display("FAIL lockout_enable_ignored: busy/armed=%b want 10", {busy, armed});
    else n_pass++;
    hold(4'b0100, 4);
    button_level = 4'd0;
    wait_idle("lockout", 200);
    @(negedge clock);
    n_checks++;
    if ({armed, votes_total} !== {1'b0, 16'd4})
      $display("FAIL lockout_total: armed=%b total=%0d want 0/4", armed, votes_total);
    else n_pass++;
  endtask

  task automatic test_saturation();
    force dut.votes_q = 16'hFFFE;
    @(negedge clock);
    release dut.votes_q;
    @(negedge clock);
    n_checks++;
    if (votes_total !== 16'hFFFE) $display("FAIL sat_preload: got %h want fffe", votes_total);
    else n_pass++;
    cast_vote("sat1", 4'b0100);
    n_checks++;
    if (votes_total !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", votes_total);
    else n_pass++;
    cast_vote("sat2", 4'b1000);
    n_checks++;
    if (votes_total !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", votes_total);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    open_ballot("rstmid");
    hold(4'b1000, 2);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({cand_inc, valid_vote_casted, multi_press, ballot_timeout, armed, busy} !== 9'd0)
      $display("FAIL rstmid_outputs: got %b want 0",
               {cand_inc, valid_vote_casted, multi_press, ballot_timeout, armed, busy});
    else n_pass++;
    n_checks++;
    if (votes_total !== 16'd0) $display("FAIL rstmid_votes: got %h want 0000", votes_total);
    else n_pass++;
    reset = 1'b0;
    hold(4'b1000, 6);
    button_level = 4'd0;
    @(negedge clock);
    n_checks++;
    if ({armed, busy} !== 2'b00) $display("FAIL rstmid_after: armed/busy=%b want 00", {armed, busy});
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; ballot_enable = 1'b0; button_level = 4'd0;
    @(negedge clock);
    test_reset();
    test_basic_vote();
    test_glitch();
    test_multi();
    test_timeout();
    test_mode_lockout();
    test_saturation();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL missing_strobes: %0d expected votes never seen", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
